// File: rtl/microc_pkg.sv
// microc control-unit shared types: FSM states, opcode classes, ALU codes.
// No logic; constants only.
// Imported by the decoder and the control-unit top.
package microc_pkg;

  localparam int OPCODE_W = 6;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Opcode classes, matched against ir[5:2] when ir[5] is clear
  localparam logic [3:0] OP_LI  = 4'b0000;
  localparam logic [3:0] OP_J   = 4'b0001;
  localparam logic [3:0] OP_JZ  = 4'b0010;
  localparam logic [3:0] OP_JNZ = 4'b0011;
  localparam logic [3:0] OP_NOP = 4'b0100;

  localparam logic [2:0] ALU_MOV  = 3'b000;
  localparam logic [2:0] ALU_NOTA = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

  // Control bundle driven towards the datapath
  typedef struct packed {
    logic       s_inc;
    logic       s_inm;
    logic       we;
    logic       wez;
    logic [2:0] alu_op;
    logic       pc_we;
  } ctrl_t;

  // Idle bundle: no writes, PC mux on increment, ALU on MOV
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c        = '0;
    c.s_inc  = 1'b1;
    c.alu_op = ALU_MOV;
    return c;
  endfunction

endpackage

// File: rtl/microc_uc_dec.sv
// microc instruction decoder: (ir, zero) -> control bundle plus illegal flag.
// Purely combinational, zero latency.
// No handshake; the top gates the bundle with the EXEC state.
module microc_uc_dec
  import microc_pkg::*;
(
  input  logic [5:0] ir,
  input  logic       zero,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // The low opcode bits carry operand selection, not control
  logic unused_ir_lo;
  assign unused_ir_lo = ^ir[1:0];

  // Decode opcode class; s_inc of the conditional jumps follows zero directly
  always_comb begin
    ctrl    = ctrl_idle();
    illegal = 1'b0;
    if (ir[5]) begin
      ctrl.alu_op = ir[4:2];
      ctrl.we     = 1'b1;
      ctrl.wez    = 1'b1;
      ctrl.pc_we  = 1'b1;
    end else begin
      case (ir[5:2])
        OP_LI: begin
          ctrl.s_inm = 1'b1;
          ctrl.we    = 1'b1;
          ctrl.pc_we = 1'b1;
        end
        OP_J: begin
          ctrl.s_inc = 1'b0;
          ctrl.pc_we = 1'b1;
        end
        OP_JZ: begin
          ctrl.s_inc = ~zero;
          ctrl.pc_we = 1'b1;
        end
        OP_JNZ: begin
          ctrl.s_inc = zero;
          ctrl.pc_we = 1'b1;
        end
        OP_NOP: begin
          ctrl.pc_we = 1'b1;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/microc_uc.sv
// microc multicycle control unit: FETCH/EXEC per instruction, HALT on illegal.
// Two cycles per instruction; outputs valid combinationally in EXEC.
// No backpressure; HALT is left only through reset.
module microc_uc #(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                zero,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we,
  output logic                wez,
  output logic [2:0]          ALUOp,
  output logic                pc_we,
  output logic                halted,
  output logic [CNT_W-1:0]    retired
);

  microc_pkg::state_t state_q;
  microc_pkg::state_t state_d;
  logic [OPCODE_W-1:0] ir;
  microc_pkg::ctrl_t   dec_ctrl;
  microc_pkg::ctrl_t   out_ctrl;
  logic                dec_illegal;

  microc_uc_dec u_dec (
    .ir      (ir[5:0]),
    .zero    (zero),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // State, instruction register and retire counter; reset wins over everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= microc_pkg::FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == microc_pkg::FETCH) begin
        ir <= Opcode;
      end
      if (state_q == microc_pkg::EXEC && !dec_illegal) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  // Next state and state-gated control outputs
  always_comb begin
    state_d  = state_q;
    out_ctrl = microc_pkg::ctrl_idle();
    case (state_q)
      microc_pkg::FETCH: begin
        state_d = microc_pkg::EXEC;
      end
      microc_pkg::EXEC: begin
        out_ctrl = dec_ctrl;
        state_d  = dec_illegal ? microc_pkg::HALT : microc_pkg::FETCH;
      end
      microc_pkg::HALT: begin
        state_d = microc_pkg::HALT;
      end
      default: begin
        state_d = microc_pkg::FETCH;
      end
    endcase
  end

  assign s_inc  = out_ctrl.s_inc;
  assign s_inm  = out_ctrl.s_inm;
  assign we     = out_ctrl.we;
  assign wez    = out_ctrl.wez;
  assign ALUOp  = out_ctrl.alu_op;
  assign pc_we  = out_ctrl.pc_we;
  assign halted = (state_q == microc_pkg::HALT);

endmodule

// File: tb/tb_microc_uc.sv
// Directed bench for microc_uc with a 4-bit retire counter.
// Inputs change and outputs are checked around the falling clock edge.
module tb_microc_uc;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             zero;
  logic             s_inc, s_inm, we, wez, pc_we, halted;
  logic [2:0]       ALUOp;
  logic [CNT_W-1:0] retired;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  microc_uc #(.OPCODE_W(6), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .Opcode  (Opcode),
    .zero    (zero),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we      (we),
    .wez     (wez),
    .ALUOp   (ALUOp),
    .pc_we   (pc_we),
    .halted  (halted),
    .retired (retired)
  );

  // One full clock: rising edge happens, then settle at the falling edge
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Leaves the DUT in FETCH with reset low
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Opcode = 6'b101000;
    zero   = 1'b0;
    do_reset();
    vectors++;
    if ({s_inc, s_inm, we, wez, ALUOp, pc_we, halted} !== 9'b1_0_0_0_000_0_0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got s_inc=%b s_inm=%b we=%b wez=%b alu=%b pc_we=%b halted=%b retired=%0d, want 1 0 0 0 000 0 0 0",
               s_inc, s_inm, we, wez, ALUOp, pc_we, halted, retired);
    end
    next_cycle();  // EXEC of ADD
    vectors++;
    if (we !== 1'b1) begin errors++; $display("FAIL add_exec_we: got %b want 1", we); end
    // Reset in the middle of the ADD execute
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    vectors++;
    if (we !== 1'b0 || pc_we !== 1'b0 || retired !== 4'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_exec: got we=%b pc_we=%b retired=%0d halted=%b want 0 0 0 0", we, pc_we, retired, halted);
    end
    next_cycle();
    vectors++;
    if (we !== 1'b1 || wez !== 1'b1 || ALUOp !== 3'b010 || pc_we !== 1'b1) begin
      errors++;
      $display("FAIL add_after_reset: got we=%b wez=%b alu=%b pc_we=%b want 1 1 010 1", we, wez, ALUOp, pc_we);
    end
  endtask

  task automatic test_li_sub();
    Opcode = 6'b000000;
    do_reset();
    next_cycle();
    vectors++;
    if (s_inm !== 1'b1 || we !== 1'b1 || wez !== 1'b0 || pc_we !== 1'b1) begin
      errors++;
      $display("FAIL li_exec: got s_inm=%b we=%b wez=%b pc_we=%b want 1 1 0 1", s_inm, we, wez, pc_we);
    end
    Opcode = 6'b101100;
    next_cycle();
    vectors++;
    if (retired !== 4'd1 || we !== 1'b0) begin
      errors++;
      $display("FAIL li_retire: got retired=%0d we=%b want 1 0", retired, we);
    end
    next_cycle();
    vectors++;
    if (ALUOp !== 3'b011 || wez !== 1'b1 || s_inm !== 1'b0 || we !== 1'b1) begin
      errors++;
      $display("FAIL sub_exec: got alu=%b wez=%b s_inm=%b we=%b want 011 1 0 1", ALUOp, wez, s_inm, we);
    end
    next_cycle();
    vectors++;
    if (retired !== 4'd2) begin errors++; $display("FAIL sub_retire: got %0d want 2", retired); end
  endtask

  task automatic test_jumps();
    Opcode = 6'b001100;  // JNZ
    zero   = 1'b0;
    do_reset();
    next_cycle();
    vectors++;
    if (s_inc !== 1'b0 || pc_we !== 1'b1 || we !== 1'b0) begin
      errors++;
      $display("FAIL jnz_z0: got s_inc=%b pc_we=%b we=%b want 0 1 0", s_inc, pc_we, we);
    end
    zero = 1'b1;
    #1;
    vectors++;
    if (s_inc !== 1'b1) begin errors++; $display("FAIL jnz_z1: got s_inc=%b want 1", s_inc); end
    Opcode = 6'b001000;  // JZ
    next_cycle();
    next_cycle();
    vectors++;
    if (s_inc !== 1'b0 || pc_we !== 1'b1) begin
      errors++;
      $display("FAIL jz_z1: got s_inc=%b pc_we=%b want 0 1", s_inc, pc_we);
    end
    zero = 1'b0;
    #1;
    vectors++;
    if (s_inc !== 1'b1) begin errors++; $display("FAIL jz_z0: got s_inc=%b want 1", s_inc); end
    Opcode = 6'b000100;  // J
    next_cycle();
    next_cycle();
    vectors++;
    if (s_inc !== 1'b0 || pc_we !== 1'b1 || wez !== 1'b0) begin
      errors++;
      $display("FAIL j_exec: got s_inc=%b pc_we=%b wez=%b want 0 1 0", s_inc, pc_we, wez);
    end
  endtask

  task automatic test_opcode_change();
    Opcode = 6'b000000;
    do_reset();
    next_cycle();
    Opcode = 6'b011000;  // illegal class appears while LI executes
    #1;
    vectors++;
    if (s_inm !== 1'b1 || we !== 1'b1 || pc_we !== 1'b1) begin
      errors++;
      $display("FAIL opc_change_exec: got s_inm=%b we=%b pc_we=%b want 1 1 1", s_inm, we, pc_we);
    end
    Opcode = 6'b010000;
    next_cycle();
    vectors++;
    if (halted !== 1'b0 || retired !== 4'd1) begin
      errors++;
      $display("FAIL opc_change_after: got halted=%b retired=%0d want 0 1", halted, retired);
    end
  endtask

  task automatic test_illegal();
    Opcode = 6'b010100;
    do_reset();
    next_cycle();
    vectors++;
    if (we !== 1'b0 || wez !== 1'b0 || pc_we !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL illegal_exec: got we=%b wez=%b pc_we=%b halted=%b want 0 0 0 0", we, wez, pc_we, halted);
    end
    Opcode = 6'b000000;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      vectors++;
      if (halted !== 1'b1 || retired !== 4'd0 || we !== 1'b0 || pc_we !== 1'b0 || s_inc !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got halted=%b retired=%0d we=%b pc_we=%b s_inc=%b want 1 0 0 0 1",
                 i, halted, retired, we, pc_we, s_inc);
      end
    end
    do_reset();
    vectors++;
    if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b want 0", halted); end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] exp_cnt;
    Opcode = 6'b010000;  // NOP
    do_reset();
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      vectors++;
      if (pc_we !== 1'b1 || we !== 1'b0 || wez !== 1'b0) begin
        errors++;
        $display("FAIL nop_exec[%0d]: got pc_we=%b we=%b wez=%b want 1 0 0", i, pc_we, we, wez);
      end
      next_cycle();
      exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (retired !== exp_cnt) begin
        errors++;
        $display("FAIL nop_count[%0d]: got %0d want %0d", i, retired, exp_cnt);
      end
    end
    vectors++;
    if (retired !== 4'd0) begin errors++; $display("FAIL nop_wrap: got %0d want 0", retired); end
  endtask

  initial begin
    reset  = 1'b1;
    Opcode = '0;
    zero   = 1'b0;
    test_reset();
    test_li_sub();
    test_jumps();
    test_opcode_change();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/microc_uc.md
Name: microc_uc

Overview:
Multicycle control unit for the microc datapath. It sits at the other end of the datapath's control interface: it consumes Opcode and zero, and drives s_inc, s_inm, we, wez, ALUOp plus a PC write strobe. Each instruction takes two cycles (FETCH, EXEC). The block also keeps a retired-instruction counter and halts on an illegal opcode.

Parameters:
OPCODE_W, 6, width of the Opcode input.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
Opcode  input  OPCODE_W  opcode field of the instruction currently addressed by the PC.
zero  input  1  registered zero flag from the datapath.
s_inc  output  1  PC mux select: 1 = PC+1, 0 = jump target.
s_inm  output  1  register-file write mux: 1 = immediate, 0 = ALU result.
we  output  1  register-file write enable.
wez  output  1  zero-flag write enable.
ALUOp  output  3  ALU operation select.
pc_we  output  1  PC load enable.
halted  output  1  high while in the HALT state.
retired  output  CNT_W  count of executed instructions.

Behaviour:
- States: FETCH, EXEC, HALT. The reset value of the state is FETCH. reset has priority over every other event, including the HALT state and the middle of an instruction.
- Reset values: s_inc=1, s_inm=0, we=0, wez=0, ALUOp=3'b000, pc_we=0, halted=0, retired=0. The internal opcode register ir is cleared to 0.
- FETCH: all strobes are 0 (we, wez, pc_we), s_inc=1, ALUOp=0. At the clock edge, ir <= Opcode. Next state is EXEC unconditionally.
- EXEC: outputs are decoded from ir (Moore on ir). The only exception is s_inc, which also depends combinationally on the current zero input.
- Decode in EXEC:
  - ir[5]=1, ALU reg-reg: ALUOp=ir[4:2], we=1, wez=1, s_inm=0, s_inc=1, pc_we=1.
  - ir[5:2]=4'b0000, LI: s_inm=1, we=1, wez=0, s_inc=1, pc_we=1.
  - ir[5:2]=4'b0001, J: s_inc=0, pc_we=1, we=0, wez=0.
  - ir[5:2]=4'b0010, JZ: s_inc=~zero, pc_we=1.
  - ir[5:2]=4'b0011, JNZ: s_inc=zero, pc_we=1.
  - ir[5:2]=4'b0100, NOP: pc_we=1, s_inc=1, no other writes.
  - Every other value (0101, 0110, 0111) is illegal: all strobes are 0, pc_we=0, and the next state is HALT.
- EXEC to FETCH for every legal opcode. On that edge retired <= retired+1. The counter wraps modulo 2^CNT_W, so all-ones goes to 0 with no sticky bit.
- HALT: all strobes are 0, s_inc=1, halted=1, retired is frozen. HALT is exited only by reset.
- zero is sampled in EXEC only. A wez write in one EXEC is therefore visible to a conditional jump in the next instruction's EXEC (two cycles later).
- Throughput: one instruction per 2 cycles. The first EXEC happens in the second cycle after reset deasserts.
- Opcode changes during EXEC are ignored, because only ir is decoded.
- ALUOp encoding: 000 pass A (MOV), 001 ~A, 010 add, 011 sub, 100 and, 101 or, 110 -A, 111 -B.

Decomposition:
- Package microc_pkg holds:
  - the state enum (FETCH/EXEC/HALT);
  - opcode class constants (OP_LI=4'b0000, OP_J=4'b0001, OP_JZ=4'b0010, OP_JNZ=4'b0011, OP_NOP=4'b0100);
  - ALUOp constants (ALU_MOV…ALU_NEGB);
  - OPCODE_W.
- One sub-module is natural: microc_uc_dec, a purely combinational decoder from (ir, zero) to the strobe bundle plus an illegal flag. The top holds the FSM, ir and the counter, and gates the strobes with state==EXEC.

Test Plan:
1. Reset mid-EXEC of an ADD (Opcode=6'b101000): assert reset for 1 cycle. Next cycle we=0, pc_we=0, retired=0, state FETCH. The following EXEC (2 cycles after reset drops) shows we=1, wez=1, ALUOp=3'b010.
2. LI (6'b000000) then SUB (6'b101100). In the LI EXEC: s_inm=1, we=1, wez=0. In the SUB EXEC: ALUOp=3'b011, wez=1, s_inm=0. retired=2 after 4 cycles.
3. JNZ (6'b001100) with zero=0 gives s_inc=0, pc_we=1. With zero=1 it gives s_inc=1. JZ (6'b001000) gives the inverse. Toggle zero inside EXEC and check that s_inc follows combinationally.
4. Change Opcode to 6'b011000 during EXEC of an LI: decode stays LI (s_inm=1, we=1), with no HALT.
5. Illegal opcode 6'b010100: in EXEC all strobes are 0 and pc_we=0. halted=1 from the next cycle and stays set for 10 cycles with retired frozen. Reset clears halted to 0.
6. With CNT_W=4, run 16 NOPs (6'b010000): retired goes 15 then wraps to 0. pc_we=1 and we=0 in every EXEC.
